// File: rtl/core_fetch_pkg.sv
// core_fetch_pkg: shared definitions for the core fetch sequencer.
// Contents:
//   fetch_state_t  - fetch FSM state encoding
//   LINE_BYTES_DEF - default I-cache line size in bytes
//   line_align     - clears the byte-offset bits of an address for a given line size
package core_fetch_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    MISS_REQ  = 2'b01,
    MISS_WAIT = 2'b10
  } fetch_state_t;

  localparam int LINE_BYTES_DEF = 16;

  // line_bytes must be a power of two, so (line_bytes - 1) is the offset mask.
  function automatic logic [31:0] line_align(input logic [31:0] addr,
                                             input int unsigned line_bytes);
    logic [31:0] mask;
    mask = line_bytes[31:0] - 32'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/core_sat_cnt.sv
// core_sat_cnt: up-counter that holds at all-ones instead of wrapping.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset, clears count
//   inc   - increment request for this cycle
//   count - current count, W bits
module core_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count register: increment while below the all-ones ceiling.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {W{1'b0}};
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1'b1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/core_fetch_ctrl.sv
// core_fetch_ctrl: fetch sequencer between the program counter, I-cache tag
// logic and decode. Drives PC advance/redirect, runs the I-cache miss
// request/ack/refill sequence, and buffers decode redirects seen during a miss.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   pc_in                  - current PC
//   ic_hit                 - I-cache hit for pc_in
//   id_stall               - decode cannot accept an instruction
//   id_redirect, id_target - decode mispredict and its correct PC
//   mem_ack                - memory accepted the miss request
//   refill_done            - one-cycle pulse, line for miss_addr is written
//   pc_go, pc_redirect     - PC advance / select pc_target
//   pc_target              - redirect target
//   stall                  - invalidates the fetched slot
//   if_valid, if_flush     - IF/ID valid and kill
//   miss_req, miss_addr    - line-fill request and line-aligned address
//   miss_cnt, miss_cyc     - saturating miss count and miss-cycle count
module core_fetch_ctrl
  import core_fetch_pkg::*;
#(
  parameter int LINE_BYTES = LINE_BYTES_DEF,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_in,
  input  logic             ic_hit,
  input  logic             id_stall,
  input  logic             id_redirect,
  input  logic [31:0]      id_target,
  input  logic             mem_ack,
  input  logic             refill_done,
  output logic             pc_go,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic             stall,
  output logic             if_valid,
  output logic             if_flush,
  output logic             miss_req,
  output logic [31:0]      miss_addr,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] miss_cyc
);

  fetch_state_t state_r;
  logic         pend_v_r;
  logic [31:0]  pend_tgt_r;
  logic [31:0]  miss_addr_r;
  logic         redir_s;
  logic         miss_start_s;
  logic         miss_busy_s;

  // A buffered redirect is replayed exactly like a fresh one; a fresh one wins the target.
  assign redir_s     = id_redirect | pend_v_r;
  assign pc_target   = id_redirect ? id_target : pend_tgt_r;
  assign miss_req    = (state_r == MISS_REQ);
  assign miss_addr   = miss_addr_r;
  assign miss_busy_s = (state_r != RUN);

  // Per-cycle fetch decisions; only RUN ever lets the PC move.
  always_comb begin
    pc_go        = 1'b0;
    pc_redirect  = 1'b0;
    stall        = 1'b0;
    if_valid     = 1'b0;
    if_flush     = 1'b0;
    miss_start_s = 1'b0;
    case (state_r)
      RUN: begin
        if (redir_s) begin
          pc_go       = 1'b1;
          pc_redirect = 1'b1;
          stall       = 1'b1;
          if_flush    = 1'b1;
        end else if (!ic_hit) begin
          miss_start_s = 1'b1;
        end else if (id_stall) begin
          if_valid = 1'b1;
        end else begin
          pc_go    = 1'b1;
          if_valid = 1'b1;
        end
      end
      default: begin
        pc_go = 1'b0;
      end
    endcase
  end

  // FSM, redirect buffer and miss address; the outstanding request is never aborted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= RUN;
      pend_v_r    <= 1'b0;
      pend_tgt_r  <= 32'd0;
      miss_addr_r <= 32'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (redir_s) begin
            pend_v_r <= 1'b0;
          end else if (miss_start_s) begin
            miss_addr_r <= line_align(pc_in, LINE_BYTES);
            state_r     <= MISS_REQ;
          end else begin
            state_r <= RUN;
          end
        end
        MISS_REQ: begin
          if (id_redirect) begin
            pend_v_r   <= 1'b1;
            pend_tgt_r <= id_target;
          end else begin
            pend_v_r <= pend_v_r;
          end
          if (mem_ack) begin
            state_r <= MISS_WAIT;
          end else begin
            state_r <= MISS_REQ;
          end
        end
        MISS_WAIT: begin
          if (id_redirect) begin
            pend_v_r   <= 1'b1;
            pend_tgt_r <= id_target;
          end else begin
            pend_v_r <= pend_v_r;
          end
          if (refill_done) begin
            state_r <= RUN;
          end else begin
            state_r <= MISS_WAIT;
          end
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

  core_sat_cnt #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_start_s),
    .count (miss_cnt)
  );

  core_sat_cnt #(.W(CNT_W)) u_miss_cyc (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_busy_s),
    .count (miss_cyc)
  );

endmodule

// File: tb/tb_core_fetch_ctrl.sv
// tb_core_fetch_ctrl: scoreboard bench for core_fetch_ctrl. Two instances share
// the same stimulus: one with 16-bit counters and one with 4-bit counters so
// saturation is reachable in a short run. Each stimulus cycle pushes its
// hand-computed expected outputs; a monitor pops and compares on the falling edge.
module tb_core_fetch_ctrl;
  timeunit 1ns;
  timeprecision 1ns;

  typedef struct packed {
    logic        go;
    logic        rd;
    logic        st;
    logic        vl;
    logic        fl;
    logic        rq;
    logic [31:0] tgt;
    logic [31:0] ma;
    logic [31:0] cnt;
    logic [31:0] cyc;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = 32'h0004_0000;
  logic        ic_hit = 1'b1;
  logic        id_stall = 1'b0;
  logic        id_redirect = 1'b0;
  logic [31:0] id_target = 32'd0;
  logic        mem_ack = 1'b0;
  logic        refill_done = 1'b0;

  logic        pc_go, pc_redirect, stall, if_valid, if_flush, miss_req;
  logic [31:0] pc_target, miss_addr;
  logic [15:0] miss_cnt, miss_cyc;

  logic        s_pc_go, s_pc_redirect, s_stall, s_if_valid, s_if_flush, s_miss_req;
  logic [31:0] s_pc_target, s_miss_addr;
  logic [3:0]  s_miss_cnt, s_miss_cyc;

  rec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  core_fetch_ctrl dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .ic_hit(ic_hit), .id_stall(id_stall),
    .id_redirect(id_redirect), .id_target(id_target), .mem_ack(mem_ack),
    .refill_done(refill_done), .pc_go(pc_go), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .stall(stall), .if_valid(if_valid), .if_flush(if_flush),
    .miss_req(miss_req), .miss_addr(miss_addr), .miss_cnt(miss_cnt), .miss_cyc(miss_cyc)
  );

  core_fetch_ctrl #(.LINE_BYTES(16), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .pc_in(pc_in), .ic_hit(ic_hit), .id_stall(id_stall),
    .id_redirect(id_redirect), .id_target(id_target), .mem_ack(mem_ack),
    .refill_done(refill_done), .pc_go(s_pc_go), .pc_redirect(s_pc_redirect),
    .pc_target(s_pc_target), .stall(s_stall), .if_valid(s_if_valid), .if_flush(s_if_flush),
    .miss_req(s_miss_req), .miss_addr(s_miss_addr), .miss_cnt(s_miss_cnt), .miss_cyc(s_miss_cyc)
  );

  function automatic rec_t mk(input logic go, input logic rd, input logic st,
                              input logic vl, input logic fl, input logic rq,
                              input logic [31:0] tgt, input logic [31:0] ma,
                              input int cnt, input int cyc);
    rec_t r;
    r.go = go; r.rd = rd; r.st = st; r.vl = vl; r.fl = fl; r.rq = rq;
    r.tgt = tgt; r.ma = ma; r.cnt = 32'(cnt); r.cyc = 32'(cyc);
    return r;
  endfunction

  function automatic logic [31:0] sat15(input logic [31:0] v);
    return (v > 32'd15) ? 32'd15 : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input rec_t a, input rec_t e);
    chk({tag, ".pc_go"},       32'(a.go),  32'(e.go));
    chk({tag, ".pc_redirect"}, 32'(a.rd),  32'(e.rd));
    chk({tag, ".stall"},       32'(a.st),  32'(e.st));
    chk({tag, ".if_valid"},    32'(a.vl),  32'(e.vl));
    chk({tag, ".if_flush"},    32'(a.fl),  32'(e.fl));
    chk({tag, ".miss_req"},    32'(a.rq),  32'(e.rq));
    chk({tag, ".pc_target"},   a.tgt, e.tgt);
    chk({tag, ".miss_addr"},   a.ma,  e.ma);
    chk({tag, ".miss_cnt"},    a.cnt, e.cnt);
    chk({tag, ".miss_cyc"},    a.cyc, e.cyc);
  endtask

  // Monitor: one expected record per stimulus cycle, compared mid-cycle.
  always @(negedge clk) begin
    rec_t e, es, a, as;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = mk(pc_go, pc_redirect, stall, if_valid, if_flush, miss_req,
             pc_target, miss_addr, int'(miss_cnt), int'(miss_cyc));
      cmp("main", a, e);
      es = e;
      es.cnt = sat15(e.cnt);
      es.cyc = sat15(e.cyc);
      as = mk(s_pc_go, s_pc_redirect, s_stall, s_if_valid, s_if_flush, s_miss_req,
              s_pc_target, s_miss_addr, int'(s_miss_cnt), int'(s_miss_cyc));
      cmp("small", as, es);
    end
  end

  task automatic step(input logic r, input logic [31:0] pc, input logic hit,
                      input logic stl, input logic red, input logic [31:0] tgt,
                      input logic ack, input logic rd, input rec_t e);
    @(posedge clk);
    #1;
    rst = r; pc_in = pc; ic_hit = hit; id_stall = stl;
    id_redirect = red; id_target = tgt; mem_ack = ack; refill_done = rd;
    exp_q.push_back(e);
  endtask

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, then plain hits.
    step(1'b1, 32'h0004_0000, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, mk(1,0,0,1,0,0, 32'd0, 32'd0, 0, 0));
    step(1'b1, 32'h0004_0000, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, mk(1,0,0,1,0,0, 32'd0, 32'd0, 0, 0));
    for (int i = 0; i < 3; i++)
      step(1'b0, 32'h0004_0000 + 32'(i * 4), 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, mk(1,0,0,1,0,0, 32'd0, 32'd0, 0, 0));

    // Miss at 0x0004_0024: two cycles without ack, ack, then refill 5 cycles later.
    step(1'b0, 32'h0004_0024, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0, 32'd0, 32'd0, 0, 0));
    step(1'b0, 32'h0004_0024, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, mk(0,0,0,0,0,1, 32'd0, 32'h0004_0020, 1, 0));
    step(1'b0, 32'h0004_0024, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, mk(0,0,0,0,0,1, 32'd0, 32'h0004_0020, 1, 1));
    step(1'b0, 32'h0004_0024, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, mk(0,0,0,0,0,1, 32'd0, 32'h0004_0020, 1, 2));
    step(1'b0, 32'h0004_0024, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, mk(0,0,0,0,0,0, 32'd0, 32'h0004_0020, 1, 3));
    for (int i = 0; i < 3; i++)
      step(1'b0, 32'h0004_0024, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0, 32'd0, 32'h0004_0020, 1, 4 + i));
    step(1'b0, 32'h0004_0024, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, mk(0,0,0,0,0,0, 32'd0, 32'h0004_0020, 1, 7));
    // Replay lookup hits; a stray refill_done in RUN does nothing.
    step(1'b0, 32'h0004_0024, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, mk(1,0,0,1,0,0, 32'd0, 32'h0004_0020, 1, 8));
    step(1'b0, 32'h0004_0028, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, mk(1,0,0,1,0,0, 32'd0, 32'h0004_0020, 1, 8));

    // Decode stall holds the slot.
    step(1'b0, 32'h0004_002C, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, mk(0,0,0,1,0,0, 32'd0, 32'h0004_0020, 1, 8));
    // Redirect beats a miss, then beats a stall.
    step(1'b0, 32'h0004_002C, 1'b0, 1'b0, 1'b1, 32'h0004_0100, 1'b0, 1'b0, mk(1,1,1,0,1,0, 32'h0004_0100, 32'h0004_0020, 1, 8));
    step(1'b0, 32'h0004_0100, 1'b1, 1'b1, 1'b1, 32'h0004_0104, 1'b0, 1'b0, mk(1,1,1,0,1,0, 32'h0004_0104, 32'h0004_0020, 1, 8));
    step(1'b0, 32'h0004_0104, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, mk(1,0,0,1,0,0, 32'd0, 32'h0004_0020, 1, 8));

    // Miss at 0x0005_0018 with a redirect arriving in MISS_WAIT.
    step(1'b0, 32'h0005_0018, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0, 32'd0, 32'h0004_0020, 1, 8));
    step(1'b0, 32'h0005_0018, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, mk(0,0,0,0,0,1, 32'd0, 32'h0005_0010, 2, 8));
    step(1'b0, 32'h0005_0018, 1'b0, 1'b0, 1'b1, 32'h0004_0200, 1'b0, 1'b0, mk(0,0,0,0,0,0, 32'h0004_0200, 32'h0005_0010, 2, 9));
    step(1'b0, 32'h0005_0018, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0, 32'h0004_0200, 32'h0005_0010, 2, 10));
    step(1'b0, 32'h0005_0018, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, mk(0,0,0,0,0,0, 32'h0004_0200, 32'h0005_0010, 2, 11));
    step(1'b0, 32'h0005_0018, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, mk(1,1,1,0,1,0, 32'h0004_0200, 32'h0005_0010, 2, 12));
    step(1'b0, 32'h0004_0200, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, mk(1,0,0,1,0,0, 32'h0004_0200, 32'h0005_0010, 2, 12));

    // Redirect and refill_done in the same MISS_WAIT cycle.
    step(1'b0, 32'h0006_0000, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0, 32'h0004_0200, 32'h0005_0010, 2, 12));
    step(1'b0, 32'h0006_0000, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, mk(0,0,0,0,0,1, 32'h0004_0200, 32'h0006_0000, 3, 12));
    step(1'b0, 32'h0006_0000, 1'b0, 1'b0, 1'b1, 32'h0004_0300, 1'b0, 1'b1, mk(0,0,0,0,0,0, 32'h0004_0300, 32'h0006_0000, 3, 13));
    step(1'b0, 32'h0006_0000, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, mk(1,1,1,0,1,0, 32'h0004_0300, 32'h0006_0000, 3, 14));
    step(1'b0, 32'h0004_0300, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, mk(1,0,0,1,0,0, 32'h0004_0300, 32'h0006_0000, 3, 14));

    // Reset while in MISS_REQ; later refill_done and mem_ack in RUN are ignored.
    step(1'b0, 32'h0007_0044, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0, 32'h0004_0300, 32'h0006_0000, 3, 14));
    step(1'b0, 32'h0007_0044, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, mk(0,0,0,0,0,1, 32'h0004_0300, 32'h0007_0040, 4, 14));
    step(1'b1, 32'h0007_0044, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, mk(0,0,0,0,0,1, 32'h0004_0300, 32'h0007_0040, 4, 15));
    step(1'b0, 32'h0007_0044, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, mk(1,0,0,1,0,0, 32'd0, 32'd0, 0, 0));
    step(1'b0, 32'h0007_0048, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, mk(1,0,0,1,0,0, 32'd0, 32'd0, 0, 0));

    // 19 back-to-back minimum-latency misses: the 4-bit instance saturates at 4'hF.
    for (int k = 0; k < 19; k++) begin
      logic [31:0] pc_k, line_k, prev_k;
      pc_k   = 32'h0008_0004 + 32'(k * 16);
      line_k = 32'h0008_0000 + 32'(k * 16);
      prev_k = (k == 0) ? 32'd0 : (32'h0008_0000 + 32'((k - 1) * 16));
      step(1'b0, pc_k, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0, 32'd0, prev_k, k, 2 * k));
      step(1'b0, pc_k, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, mk(0,0,0,0,0,1, 32'd0, line_k, k + 1, 2 * k));
      step(1'b0, pc_k, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, mk(0,0,0,0,0,0, 32'd0, line_k, k + 1, 2 * k + 1));
    end
    step(1'b0, 32'h0008_0124, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, mk(1,0,0,1,0,0, 32'd0, 32'h0008_0120, 19, 38));

    // Let the monitor drain the queue, with a bounded wait.
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d records left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
